// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                      |
// | Description : Shared definitions for the PS/2 receiver: the frame FSM      |
// |               state encoding, the data width of one PS/2 byte and the      |
// |               odd-parity check used on every received frame.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: the eight data bits plus the parity bit must hold
  // an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_rx_fifo                                                  |
// | Description : First-word-fall-through byte FIFO for received scan codes.   |
// |               dout always shows the oldest entry while empty is low.       |
// |               A push while full is accepted only if a pop happens in the   |
// |               same cycle; otherwise it is ignored (caller flags overflow). |
// | Ports       : Clock, Resetn (async, active low)                            |
// |               push/din  - write one byte                                   |
// |               pop       - drop the head entry (ignored when empty)         |
// |               dout      - head entry                                       |
// |               empty/full- occupancy flags                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PS2_DATA_BITS-1:0] din,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     empty,
  output logic                     full
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q,  count_d;
  logic                     do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_rx                                                       |
// | Description : PS/2 keyboard receiver. Synchronises ps2_clk/ps2_dat,        |
// |               samples data on each ps2_clk falling edge and assembles      |
// |               start/8 data/odd parity/stop frames. A per-frame watchdog    |
// |               aborts frames whose ps2_clk stalls.                          |
// | Config      : PS2_RX_FIFO_EN - when defined, good bytes go into a          |
// |               FIFO_DEPTH first-word-fall-through FIFO popped by key_read;  |
// |               otherwise scan_code holds the last byte and key_valid is a   |
// |               one-cycle strobe.                                            |
// | Ports       : Clock, Resetn (async, active low)                            |
// |               ps2_clk, ps2_dat - raw keyboard lines (async, idle high)     |
// |               key_read         - pop strobe (FIFO build only)              |
// |               scan_code        - received byte                             |
// |               key_valid        - scan_code valid                           |
// |               parity_err/frame_err/overflow - one-cycle error pulses       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  input  logic                     key_read,
  output logic [PS2_DATA_BITS-1:0] scan_code,
  output logic                     key_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int               CNT_W    = $clog2(PS2_DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PS2_DATA_BITS - 1);

  logic                     clk_s1_q, clk_s2_q, clk_prev_q;
  logic                     dat_s1_q, dat_s2_q;
  logic                     ps2_fall;
  ps2_state_e               state_q,   state_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q,   shift_d;
  logic                     par_q,     par_d;
  logic [TMO_W-1:0]         tmo_q,     tmo_d;
  logic                     perr_q,    perr_d;
  logic                     ferr_q,    ferr_d;
  logic                     deliver;

  assign ps2_fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    deliver   = 1'b0;
    if (ps2_fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;          // bad start bit
          end
        end
        DATA: begin
          // Shift in at the MSB so the first bit ends up in bit 0.
          shift_d = {dat_s2_q, shift_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        default: begin              // STOP
          if (!dat_s2_q) begin
            ferr_d = 1'b1;          // framing outranks parity
          end else if (odd_parity_ok(shift_q, par_q)) begin
            deliver = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        ferr_d    = 1'b1;
        state_d   = IDLE;
        tmo_d     = '0;
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

`ifdef PS2_RX_FIFO_EN
  logic                     fifo_pop, fifo_empty, fifo_full;
  logic [PS2_DATA_BITS-1:0] fifo_dout;
  logic                     overflow_q, overflow_d;

  assign fifo_pop   = key_read & ~fifo_empty;
  assign overflow_d = deliver & fifo_full & ~fifo_pop;

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Resetn (Resetn),
    .push   (deliver),
    .pop    (fifo_pop),
    .din    (shift_q),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign scan_code = fifo_dout;
  assign key_valid = ~fifo_empty;
  assign overflow  = overflow_q;
`else
  logic [PS2_DATA_BITS-1:0] scan_code_q, scan_code_d;
  logic                     key_valid_q, key_valid_d;
  logic [31:0]              unused_cfg;

  // FIFO_DEPTH and key_read have no role without the FIFO.
  assign unused_cfg = 32'(FIFO_DEPTH) ^ {31'd0, key_read};

  always_comb begin
    scan_code_d = deliver ? shift_q : scan_code_q;
    key_valid_d = deliver;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      scan_code_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      scan_code_q <= scan_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign scan_code = scan_code_q;
  assign key_valid = key_valid_q;
  assign overflow  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_rx                                                    |
// | Description : Self-checking bench for ps2_rx. Frames are generated from   |
// |               random bytes and error choices; a frame-level model predicts |
// |               which byte or error pulse each frame must produce, and a     |
// |               per-cycle monitor compares the DUT outputs with it.          |
// |               Build with PS2_RX_FIFO_EN to exercise the FIFO variant.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_rx;

  localparam int TMO   = 64;
  localparam int DEPTH = 16;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       key_read;
  logic [7:0] scan_code;
  logic       key_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_perr = 0;
  int cnt_ferr = 0;
  int cnt_ovf  = 0;
  int cnt_kv   = 0;

  logic       prev_perr = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovf  = 1'b0;
  logic       prev_kv   = 1'b0;
  logic [7:0] exp_del[$];          // bytes expected on the next key_valid strobes
  logic [7:0] fifo_m[$];           // expected FIFO contents, head first
  logic [7:0] last_code = 8'h00;   // byte scan_code must hold between strobes
  logic       settled   = 1'b1;    // model and FIFO outputs are comparable

  ps2_rx #(
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .key_read   (key_read),
    .scan_code  (scan_code),
    .key_valid  (key_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor.
  initial begin
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        prev_perr = 1'b0;
        prev_ferr = 1'b0;
        prev_ovf  = 1'b0;
        prev_kv   = 1'b0;
      end else begin
        chk("err_exclusive", 32'($countones({parity_err, frame_err, overflow}) <= 1), 1);
        chk("perr_one_cycle", parity_err & prev_perr, 0);
        chk("ferr_one_cycle", frame_err & prev_ferr, 0);
        chk("ovf_one_cycle", overflow & prev_ovf, 0);
        if (parity_err) cnt_perr++;
        if (frame_err)  cnt_ferr++;
        if (overflow)   cnt_ovf++;
`ifdef PS2_RX_FIFO_EN
        if (settled) begin
          chk("kv_vs_model", key_valid, fifo_m.size() != 0);
          if (fifo_m.size() != 0) chk("head_vs_model", scan_code, fifo_m[0]);
        end
`else
        chk("overflow_tied", overflow, 0);
        chk("kv_one_cycle", key_valid & prev_kv, 0);
        if (key_valid) begin
          cnt_kv++;
          chk("kv_expected", exp_del.size() != 0, 1);
          if (exp_del.size() != 0) begin
            chk("scan_code_vs_model", scan_code, exp_del[0]);
            last_code = exp_del.pop_front();
          end
        end else begin
          chk("scan_code_hold", scan_code, last_code);
        end
`endif
        prev_perr = parity_err;
        prev_ferr = frame_err;
        prev_ovf  = overflow;
        prev_kv   = key_valid;
      end
    end
  end

  // One PS/2 bit: data set while the clock is high, then a low phase.
  task automatic ps2_bit(input logic b);
    int h;
    h = $urandom_range(3, 10);
    @(posedge Clock); #1 ps2_dat = b;
    repeat (h) @(posedge Clock);
    #1 ps2_clk = 1'b0;
    repeat (h) @(posedge Clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic pop_one();
    @(posedge Clock); #1 key_read = 1'b1;
    @(posedge Clock); #1 key_read = 1'b0;
`ifdef PS2_RX_FIFO_EN
    if (fifo_m.size() != 0) void'(fifo_m.pop_front());
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    int   p0, f0, o0, k0;
    logic par, good, exp_ovf;
    p0 = cnt_perr; f0 = cnt_ferr; o0 = cnt_ovf; k0 = cnt_kv;
    par     = (~^d) ^ bad_par;
    good    = !bad_par && !bad_stop;
    exp_ovf = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    settled = 1'b0;
`ifndef PS2_RX_FIFO_EN
    if (good) exp_del.push_back(d);
`endif
    ps2_bit(!bad_stop);
    ps2_dat = 1'b1;
    repeat (8) @(posedge Clock);
    #1;
`ifdef PS2_RX_FIFO_EN
    if (good) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back(d);
      else exp_ovf = 1'b1;
    end
`endif
    settled = 1'b1;
    chk("frame_perr_count", 32'(cnt_perr - p0), 32'(bad_par && !bad_stop));
    chk("frame_ferr_count", 32'(cnt_ferr - f0), 32'(bad_stop));
    chk("frame_ovf_count", 32'(cnt_ovf - o0), 32'(exp_ovf));
`ifndef PS2_RX_FIFO_EN
    chk("frame_kv_count", 32'(cnt_kv - k0), 32'(good));
    chk("deliveries_drained", exp_del.size(), 0);
`endif
  endtask

  task automatic glitch();
    int f0, p0;
    f0 = cnt_ferr; p0 = cnt_perr;
    ps2_bit(1'b1);
    repeat (8) @(posedge Clock);
    #1;
    chk("glitch_ferr", 32'(cnt_ferr - f0), 1);
    chk("glitch_perr", 32'(cnt_perr - p0), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_scan_code"}, scan_code, 8'h00);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int         f0, k0, o0;
    logic [7:0] d;
    int         r;
    Resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    key_read = 1'b0;
    repeat (3) @(posedge Clock);
    #1 chk_reset_outputs("reset");
    Resetn = 1'b1;
    repeat (4) @(posedge Clock);

    // 8'h1C with correct parity (0).
    send_frame(8'h1C, 1'b0, 1'b0);
`ifdef PS2_RX_FIFO_EN
    chk("lit_1C_kv", key_valid, 1);
    chk("lit_1C_code", scan_code, 8'h1C);
    pop_one();
    chk("lit_1C_popped", key_valid, 0);
`else
    chk("lit_1C_code", scan_code, 8'h1C);
`endif

    // 8'h1C with parity forced to 1: parity error only.
    k0 = cnt_kv;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("lit_parerr_kv", key_valid, 0);
    chk("lit_parerr_nokv", 32'(cnt_kv - k0), 0);

    // Bad stop bit and a lone bad start bit.
    send_frame(8'hA5, 1'b0, 1'b1);
    glitch();

`ifdef PS2_RX_FIFO_EN
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("lit_F0_kv", key_valid, 1);
    chk("lit_F0_head", scan_code, 8'hF0);
    pop_one();
    chk("lit_1C_head", scan_code, 8'h1C);
    pop_one();
    chk("lit_fifo_empty", key_valid, 0);
    pop_one();                            // pop on empty is ignored
    chk("lit_empty_pop", key_valid, 0);
`endif

    // Timeout: 5 data bits then ps2_clk idles.
    f0 = cnt_ferr; k0 = cnt_kv;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom));
    repeat (TMO + 36) @(posedge Clock);
    #1;
    chk("lit_timeout_ferr", 32'(cnt_ferr - f0), 1);
    chk("lit_timeout_nokv", 32'(cnt_kv - k0), 0);
    send_frame(8'h29, 1'b0, 1'b0);
`ifdef PS2_RX_FIFO_EN
    chk("lit_29_code", scan_code, 8'h29);
    pop_one();
`else
    chk("lit_29_code", scan_code, 8'h29);
`endif

    // Randomised frames, errors and reads.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 19));
      d = 8'($urandom);
      if (r == 0) glitch();
      else send_frame(d, r == 1, r == 2);
      if ($urandom_range(0, 2) == 0) pop_one();
    end

`ifdef PS2_RX_FIFO_EN
    while (fifo_m.size() != 0) pop_one();
    chk("drained_kv", key_valid, 0);
    o0 = cnt_ovf;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1'b0, 1'b0);
    chk("lit_overflow_once", 32'(cnt_ovf - o0), 1);
    chk("lit_full_kv", key_valid, 1);
    while (fifo_m.size() != 0) pop_one();
    chk("lit_full_drained", key_valid, 0);
`else
    o0 = cnt_ovf;
    chk("lit_no_overflow", 32'(cnt_ovf - o0), 0);
`endif

    // Reset after the 4th data bit.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
    @(posedge Clock);
    #3 Resetn = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    exp_del.delete();
    fifo_m.delete();
    last_code = 8'h00;
    #1 chk_reset_outputs("midframe_reset");
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (3) @(posedge Clock);
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("lit_5A_code", scan_code, 8'h5A);

    repeat (5) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
